// File: rtl/memory_game_pkg.sv
// Shared constants, entry layout and state encoding for the memory-card game.
package memory_game_pkg;

  localparam int NUM_CARDS = 12;
  localparam int NUM_PAIRS = 6;
  localparam logic [3:0] MAX_ADDR = 4'd12;

  localparam int ACTIVE_BIT = 0;
  localparam int DISC_BIT   = 1;
  localparam int RGB_MSB    = 13;
  localparam int RGB_LSB    = 2;

  localparam logic [11:0] RED     = 12'hF00;
  localparam logic [11:0] GREEN   = 12'h0F0;
  localparam logic [11:0] BLUE    = 12'h00F;
  localparam logic [11:0] CYAN    = 12'h0FF;
  localparam logic [11:0] MAGENTA = 12'hF0F;
  localparam logic [11:0] YELLOW  = 12'hFF0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PICK1   = 3'd2,
    ST_PICK2   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_HIDE    = 3'd5,
    ST_WON     = 3'd6
  } state_t;

  function automatic logic addr_ok(input logic [3:0] a);
    return (a != 4'd0) && (a <= MAX_ADDR);
  endfunction

  function automatic logic [NUM_CARDS:1] onehot(input logic [3:0] a);
    logic [NUM_CARDS:1] m;
    m = '0;
    for (int i = 1; i <= NUM_CARDS; i++) begin
      if (a == 4'(i)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/card_regfile.sv
// 12-entry card board storage: full-entry load port, per-entry flag updates,
// two combinational compare ports and a registered renderer port.
module card_regfile
  import memory_game_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_all,
  input  logic                 wr_en,
  input  logic [3:0]           wr_addr,
  input  logic [13:0]          wr_data,
  input  logic [NUM_CARDS:1]   disc_set,
  input  logic [NUM_CARDS:1]   disc_clr,
  input  logic [NUM_CARDS:1]   act_clr,
  input  logic [3:0]           a_addr,
  output logic [13:0]          a_data,
  input  logic [3:0]           b_addr,
  output logic [13:0]          b_data,
  input  logic [3:0]           rd_addr,
  output logic [13:0]          rd_data
);

  logic [13:0] mem [1:NUM_CARDS];
  logic [13:0] rd_comb;

  // Addresses outside 1..12 match no entry and read as zero.
  always_comb begin
    a_data  = '0;
    b_data  = '0;
    rd_comb = '0;
    for (int i = 1; i <= NUM_CARDS; i++) begin
      if (a_addr == 4'(i))  a_data  = mem[i];
      if (b_addr == 4'(i))  b_data  = mem[i];
      if (rd_addr == 4'(i)) rd_comb = mem[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
      for (int i = 1; i <= NUM_CARDS; i++) mem[i] <= '0;
    end else begin
      rd_data <= rd_comb;
      for (int i = 1; i <= NUM_CARDS; i++) begin
        if (clear_all) begin
          mem[i] <= '0;
        end else if (wr_en && wr_addr == 4'(i)) begin
          mem[i] <= wr_data;
        end else begin
          if (disc_set[i]) mem[i][DISC_BIT]   <= 1'b1;
          if (disc_clr[i]) mem[i][DISC_BIT]   <= 1'b0;
          if (act_clr[i])  mem[i][ACTIVE_BIT] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/card_board_ctl.sv
// Memory-game board controller: loads the board from the colour generator and
// runs the pick/compare/hide loop. MOVE_COUNTER_EN builds the saturating move counter.
module card_board_ctl
  import memory_game_pkg::*;
#(
  parameter int HIDE_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [13:0] gen_data,
  input  logic [3:0]  gen_address,
  output logic        gen_enable,
  input  logic        sel_valid,
  input  logic [3:0]  sel_addr,
  input  logic [3:0]  rd_addr,
  output logic [13:0] rd_data,
  output logic        busy,
  output logic [2:0]  pairs_found,
  output logic [7:0]  moves,
  output logic        game_won,
  output logic [2:0]  state_dbg
);

  state_t             state;
  logic [3:0]         lat_a, lat_b;
  logic [CNT_W-1:0]   hide_cnt;
  logic [13:0]        a_data, b_data;
  logic [3:0]         a_rd_addr, b_rd_addr;
  logic [1:0]         sel_flags;
  logic               sel_legal, colours_match, wr_en, hide_done;
  logic [NUM_CARDS:1] disc_set, disc_clr, act_clr;
  logic               unused_gen_flags;

  assign state_dbg        = state;
  assign unused_gen_flags = ^gen_data[1:0];

  // Compare port A serves the PICK1 legality probe, port B the PICK2 probe;
  // both fall back to the latched pair for COMPARE and HIDE.
  assign a_rd_addr = (state == ST_PICK1) ? sel_addr : lat_a;
  assign b_rd_addr = (state == ST_PICK2) ? sel_addr : lat_b;
  assign sel_flags = (state == ST_PICK1) ? a_data[1:0] : b_data[1:0];

  // sel_valid is a single-cycle pulse with no ready: a click that is not legal
  // in the current state is dropped, never held.
  assign sel_legal = sel_valid && !start && addr_ok(sel_addr) &&
                     (state == ST_PICK1 || state == ST_PICK2) &&
                     sel_flags[ACTIVE_BIT] && !sel_flags[DISC_BIT];

  assign colours_match = (a_data[RGB_MSB:RGB_LSB] == b_data[RGB_MSB:RGB_LSB]);
  assign wr_en         = (state == ST_LOAD) && addr_ok(gen_address);
  assign hide_done     = (state == ST_HIDE) && (hide_cnt == '0);

  assign disc_set = sel_legal ? onehot(sel_addr) : '0;
  assign act_clr  = (state == ST_COMPARE && colours_match) ? (onehot(lat_a) | onehot(lat_b)) : '0;
  assign disc_clr = hide_done ? (onehot(lat_a) | onehot(lat_b)) : '0;

  card_regfile u_regfile (
    .clk       (clk),
    .rst       (rst),
    .clear_all (start),
    .wr_en     (wr_en),
    .wr_addr   (gen_address),
    .wr_data   ({gen_data[RGB_MSB:RGB_LSB], 2'b01}),
    .disc_set  (disc_set),
    .disc_clr  (disc_clr),
    .act_clr   (act_clr),
    .a_addr    (a_rd_addr),
    .a_data    (a_data),
    .b_addr    (b_rd_addr),
    .b_data    (b_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      gen_enable  <= 1'b0;
      busy        <= 1'b0;
      game_won    <= 1'b0;
      pairs_found <= '0;
      lat_a       <= '0;
      lat_b       <= '0;
      hide_cnt    <= '0;
    end else if (start) begin
      state       <= ST_LOAD;
      gen_enable  <= 1'b1;
      busy        <= 1'b1;
      game_won    <= 1'b0;
      pairs_found <= '0;
      lat_a       <= '0;
      lat_b       <= '0;
      hide_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: ;
        ST_LOAD: begin
          if (wr_en && gen_address == MAX_ADDR) begin
            state       <= ST_PICK1;
            gen_enable  <= 1'b0;
            busy        <= 1'b0;
            pairs_found <= '0;
            hide_cnt    <= '0;
          end
        end
        ST_PICK1: begin
          if (sel_legal) begin
            lat_a <= sel_addr;
            state <= ST_PICK2;
          end
        end
        ST_PICK2: begin
          if (sel_legal) begin
            lat_b <= sel_addr;
            state <= ST_COMPARE;
            busy  <= 1'b1;
          end
        end
        ST_COMPARE: begin
          if (colours_match) begin
            pairs_found <= pairs_found + 3'd1;
            busy        <= 1'b0;
            if (pairs_found == 3'(NUM_PAIRS - 1)) begin
              state    <= ST_WON;
              game_won <= 1'b1;
            end else begin
              state <= ST_PICK1;
            end
          end else begin
            hide_cnt <= CNT_W'(HIDE_CYCLES - 1);
            state    <= ST_HIDE;
          end
        end
        ST_HIDE: begin
          if (hide_cnt == '0) begin
            state <= ST_PICK1;
            busy  <= 1'b0;
          end else begin
            hide_cnt <= hide_cnt - 1'b1;
          end
        end
        ST_WON: ;
        default: begin
          state      <= ST_IDLE;
          gen_enable <= 1'b0;
          busy       <= 1'b0;
          game_won   <= 1'b0;
        end
      endcase
    end
  end

`ifdef MOVE_COUNTER_EN
  logic [7:0] moves_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      moves_q <= '0;
    end else if (start) begin
      moves_q <= '0;
    end else if (state == ST_COMPARE && moves_q != 8'hFF) begin
      moves_q <= moves_q + 8'd1;
    end
  end
  assign moves = moves_q;
`else
  assign moves = 8'd0;
`endif

endmodule

// File: tb/tb_card_board_ctl.sv
// Self-checking bench for card_board_ctl: board load, match, mismatch/hide,
// illegal picks, win/restart and asynchronous reset mid-hide.
module tb_card_board_ctl;
  import memory_game_pkg::*;

  localparam int H = 4;

  logic        clk = 1'b0;
  logic        rst, start, sel_valid, gen_enable, busy, game_won;
  logic [13:0] gen_data, rd_data;
  logic [3:0]  gen_address, sel_addr, rd_addr;
  logic [2:0]  pairs_found, state_dbg;
  logic [7:0]  moves;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [13:0] exp_q[$];
  logic [13:0] model [0:15];
  logic [11:0] colour_of [1:12];
  int          exp_pairs = 0;
  int          exp_moves_cnt = 0;

  card_board_ctl #(.HIDE_CYCLES(H), .CNT_W(26)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .gen_data    (gen_data),
    .gen_address (gen_address),
    .gen_enable  (gen_enable),
    .sel_valid   (sel_valid),
    .sel_addr    (sel_addr),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .pairs_found (pairs_found),
    .moves       (moves),
    .game_won    (game_won),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_moves();
`ifdef MOVE_COUNTER_EN
    return exp_moves_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic check_status(input string tag, input state_t st);
    logic exp_busy;
    exp_busy = (st == ST_LOAD) || (st == ST_COMPARE) || (st == ST_HIDE);
    chk({tag, ".state"}, 32'(state_dbg), 32'(st));
    chk({tag, ".busy"}, 32'(busy), 32'(exp_busy));
    chk({tag, ".pairs"}, 32'(pairs_found), 32'(exp_pairs));
    chk({tag, ".moves"}, 32'(moves), 32'(exp_moves()));
    chk({tag, ".won"}, 32'(game_won), 32'(st == ST_WON));
  endtask

  task automatic rd_issue(input logic [3:0] a);
    rd_addr = a;
    exp_q.push_back(model[a]);
  endtask

  task automatic rd_pop(input string tag);
    logic [13:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'(1), 32'(0));
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(rd_data), 32'(e));
    end
  endtask

  task automatic rd_check(input logic [3:0] a);
    rd_issue(a);
    tick();
    rd_pop($sformatf("rd[%0d]", a));
  endtask

  task automatic check_board();
    for (int a = 0; a <= 13; a++) rd_check(4'(a));
  endtask

  task automatic clear_model();
    for (int a = 0; a < 16; a++) model[a] = '0;
  endtask

  task automatic load_board();
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_model();
    exp_pairs     = 0;
    exp_moves_cnt = 0;
    check_status("start", ST_LOAD);
    gen_address = 4'd0;
    gen_data    = 14'($urandom_range(0, 16383));
    chk("gen_en.addr0", 32'(gen_enable), 32'(1));
    rd_check(4'd5);
    for (int a = 1; a <= 12; a++) begin
      gen_address = 4'(a);
      gen_data    = {colour_of[a], 2'($urandom_range(0, 3))};
      chk($sformatf("gen_en.addr%0d", a), 32'(gen_enable), 32'(1));
      tick();
      model[a] = {colour_of[a], 2'b01};
    end
    gen_address = 4'd0;
    gen_data    = 14'($urandom_range(0, 16383));
    chk("gen_en.done", 32'(gen_enable), 32'(0));
    check_status("loaded", ST_PICK1);
  endtask

  task automatic select(input logic [3:0] a, input bit legal);
    sel_valid = 1'b1;
    sel_addr  = a;
    tick();
    sel_valid = 1'b0;
    if (legal) model[a][DISC_BIT] = 1'b1;
  endtask

  // Starts in the COMPARE sample and follows the pair to PICK1/WON.
  task automatic resolve(input logic [3:0] a, input logic [3:0] b);
    tick();
    exp_moves_cnt++;
    if (colour_of[a] == colour_of[b]) begin
      model[a][ACTIVE_BIT] = 1'b0;
      model[b][ACTIVE_BIT] = 1'b0;
      exp_pairs++;
      check_status("match", (exp_pairs == NUM_PAIRS) ? ST_WON : ST_PICK1);
      rd_check(a);
      rd_check(b);
    end else begin
      for (int k = 0; k < H; k++) begin
        check_status($sformatf("hide%0d", k), ST_HIDE);
        if (k == 1) begin
          sel_valid = 1'b1;
          sel_addr  = 4'd3;
        end
        rd_issue(a);
        tick();
        sel_valid = 1'b0;
        rd_pop($sformatf("hide_rd%0d", k));
      end
      model[a][DISC_BIT] = 1'b0;
      model[b][DISC_BIT] = 1'b0;
      check_status("covered", ST_PICK1);
      rd_check(a);
      rd_check(b);
      rd_check(4'd3);
    end
  endtask

  task automatic pick_pair(input logic [3:0] a, input logic [3:0] b);
    select(a, 1'b1);
    check_status("pick1", ST_PICK2);
    select(b, 1'b1);
    check_status("pick2", ST_COMPARE);
    resolve(a, b);
  endtask

  initial begin
    colour_of[1] = RED;     colour_of[2]  = GREEN;   colour_of[3]  = BLUE;
    colour_of[4] = CYAN;    colour_of[5]  = MAGENTA; colour_of[6]  = YELLOW;
    colour_of[7] = GREEN;   colour_of[8]  = BLUE;    colour_of[9]  = CYAN;
    colour_of[10] = MAGENTA; colour_of[11] = RED;    colour_of[12] = YELLOW;
    clear_model();
    rst = 1'b1; start = 1'b0; sel_valid = 1'b0; sel_addr = '0;
    gen_address = '0; gen_data = '0; rd_addr = '0;
    tick();
    tick();
    check_status("reset", ST_IDLE);
    chk("reset.gen_en", 32'(gen_enable), 32'(0));
    chk("reset.rd", 32'(rd_data), 32'(0));
    rst = 1'b0;
    tick();
    select(4'd1, 1'b0);
    check_status("idle_sel", ST_IDLE);

    load_board();
    check_board();
    pick_pair(4'd1, 4'd2);
    pick_pair(4'd1, 4'd11);

    select(4'd0, 1'b0);  check_status("ill0", ST_PICK1);
    select(4'd13, 1'b0); check_status("ill13", ST_PICK1);
    select(4'd1, 1'b0);  check_status("ill_removed", ST_PICK1);
    select(4'd3, 1'b1);  check_status("pick3", ST_PICK2);
    select(4'd3, 1'b0);  check_status("ill_twice", ST_PICK2);
    select(4'd11, 1'b0); check_status("ill_removed2", ST_PICK2);
    select(4'd8, 1'b1);  check_status("pick8", ST_COMPARE);
    resolve(4'd3, 4'd8);
    check_board();

    pick_pair(4'd2, 4'd7);
    pick_pair(4'd4, 4'd9);
    pick_pair(4'd5, 4'd10);
    pick_pair(4'd6, 4'd12);
    select(4'd4, 1'b0);
    check_status("won_hold", ST_WON);
    check_board();

    load_board();
    check_board();
    select(4'd1, 1'b1);
    select(4'd2, 1'b1);
    tick();
    exp_moves_cnt++;
    tick();
    check_status("pre_rst", ST_HIDE);
    #2;
    rst = 1'b1;
    #1;
    clear_model();
    exp_pairs     = 0;
    exp_moves_cnt = 0;
    check_status("rst_hide", ST_IDLE);
    chk("rst_hide.gen_en", 32'(gen_enable), 32'(0));
    chk("rst_hide.rd", 32'(rd_data), 32'(0));
    tick();
    rst = 1'b0;
    check_board();
    check_status("after_rst", ST_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
